// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the turbo instruction-fetch stage.
// Bus widths, one-hot fetch FSM encodings and the default reset PC.
package fetch_stage_pkg;

    localparam int IF_TO_ID_BUS_WD = 64;
    localparam int PRDT_BUS_WD     = 33;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    typedef enum logic [4:0] {
        IF_ST_INIT = 5'b00001,
        IF_ST_REQ  = 5'b00010,
        IF_ST_RESP = 5'b00100,
        IF_ST_HOLD = 5'b01000,
        IF_ST_NEXT = 5'b10000
    } if_state_e;

    typedef struct packed {
        logic        go;
        logic [31:0] tar;
    } prdt_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_gen.sv
// Program counter register and next-PC selection for the fetch stage.
// Priority: cancel redirect, then decode's prediction, then sequential +4.
module pc_gen
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cancel,
    input  logic [31:0] cancel_tar,
    input  logic        advance,
    input  logic        prdt_go,
    input  logic [31:0] prdt_tar,
    output logic [31:0] pc
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (cancel) begin
            pc_d = cancel_tar;
        end else if (advance) begin
            pc_d = prdt_go ? prdt_tar : seq_pc(pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding fetch, handshakes to memory and decode.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cancel,
    input  logic [31:0]                cancel_tar,
    input  logic [PRDT_BUS_WD-1:0]     prdt_bus,
    input  logic                       ID_ready,
    output logic                       IF_to_ID_valid,
    output logic [IF_TO_ID_BUS_WD-1:0] IF_to_ID_bus,
    output logic [31:0]                PC,
    output logic                       Inst_Req_Valid,
    input  logic                       Inst_Req_Ready,
    input  logic [31:0]                Instruction,
    input  logic                       Inst_Valid,
    output logic                       Inst_Ready
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                Fetch_cnt,
    output logic [31:0]                Mem_wait_cnt,
    output logic [31:0]                Cancel_cnt
`endif
);

    if_state_e   state_d, state_q;
    logic        discard_d, discard_q;
    logic [31:0] inst_d, inst_q;
    logic        req_valid_d, req_valid_q;
    logic        inst_ready_d, inst_ready_q;
    logic        id_valid_d, id_valid_q;
    prdt_t       prdt;

    assign prdt = prdt_t'(prdt_bus);

    pc_gen #(
        .RESET_PC   (RESET_PC)
    ) u_pc_gen (
        .clk        (clk),
        .rst        (rst),
        .cancel     (cancel),
        .cancel_tar (cancel_tar),
        .advance    (state_q == IF_ST_NEXT),
        .prdt_go    (prdt.go),
        .prdt_tar   (prdt.tar),
        .pc         (PC)
    );

    // A cancel that cannot drop the in-flight response immediately marks it for discard.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        inst_d    = inst_q;
        unique case (state_q)
            IF_ST_INIT: begin
                if (!cancel) begin
                    state_d = IF_ST_REQ;
                end
            end
            IF_ST_REQ: begin
                if (Inst_Req_Ready) begin
                    state_d   = IF_ST_RESP;
                    discard_d = cancel;
                end
            end
            IF_ST_RESP: begin
                if (Inst_Valid) begin
                    discard_d = 1'b0;
                    if (cancel || discard_q) begin
                        state_d = IF_ST_REQ;
                    end else begin
                        state_d = IF_ST_HOLD;
                        inst_d  = Instruction;
                    end
                end else if (cancel) begin
                    discard_d = 1'b1;
                end
            end
            IF_ST_HOLD: begin
                if (cancel) begin
                    state_d = IF_ST_REQ;
                end else if (ID_ready) begin
                    state_d = IF_ST_NEXT;
                end
            end
            IF_ST_NEXT: begin
                state_d = IF_ST_REQ;
            end
            default: begin
                state_d   = IF_ST_INIT;
                discard_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        req_valid_d  = (state_d == IF_ST_REQ);
        inst_ready_d = (state_d == IF_ST_RESP);
        id_valid_d   = (state_d == IF_ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IF_ST_INIT;
            discard_q    <= 1'b0;
            inst_q       <= 32'h0;
            req_valid_q  <= 1'b0;
            inst_ready_q <= 1'b0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            discard_q    <= discard_d;
            inst_q       <= inst_d;
            req_valid_q  <= req_valid_d;
            inst_ready_q <= inst_ready_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign Inst_Req_Valid = req_valid_q;
    assign Inst_Ready     = inst_ready_q;
    assign IF_to_ID_valid = id_valid_q;
    assign IF_to_ID_bus   = {PC, inst_q};

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] mem_wait_cnt_d, mem_wait_cnt_q;
    logic [31:0] cancel_cnt_d, cancel_cnt_q;

    // Counters wrap naturally at 32 bits.
    always_comb begin
        fetch_cnt_d    = fetch_cnt_q;
        mem_wait_cnt_d = mem_wait_cnt_q;
        cancel_cnt_d   = cancel_cnt_q;
        if (state_q == IF_ST_HOLD && ID_ready && !cancel) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (state_q == IF_ST_REQ || state_q == IF_ST_RESP) begin
            mem_wait_cnt_d = mem_wait_cnt_q + 32'd1;
        end
        if (cancel) begin
            cancel_cnt_d = cancel_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q    <= 32'h0;
            mem_wait_cnt_q <= 32'h0;
            cancel_cnt_q   <= 32'h0;
        end else begin
            fetch_cnt_q    <= fetch_cnt_d;
            mem_wait_cnt_q <= mem_wait_cnt_d;
            cancel_cnt_q   <= cancel_cnt_d;
        end
    end

    assign Fetch_cnt    = fetch_cnt_q;
    assign Mem_wait_cnt = mem_wait_cnt_q;
    assign Cancel_cnt   = cancel_cnt_q;
`endif

endmodule
